// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants and helpers for the raster timing generator.
//   - Default 640x480@60 timing (800 x 525 total, ~25.175 MHz pixel clock).
//   - h_total()/v_total(): raster totals derived from the four segment lengths.
//   - coord_fits(): true when a 0..total-1 counter fits in a given width.
//   - FRAME_COUNT_W: width of the optional frame counter (VGA_FRAME_COUNT_EN).
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_COORD_REG_MAX = 11;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam bit DEF_H_SYNC_POL = 1'b0;
    localparam bit DEF_V_SYNC_POL = 1'b0;

    localparam int FRAME_COUNT_W = 16;

    function automatic int h_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // Widths of 31 and above always hold any positive int total.
    function automatic bit coord_fits(input int total, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return (total - 1) <= ((1 << width) - 1);
    endfunction

endpackage

// File: rtl/vga_timing_wrap.sv
// ----------------------------------------------------------------------------
// wrap_counter
//   Up-counter that runs 0..LIMIT and wraps to 0. Resets to LIMIT so that the
//   first enabled edge after reset lands on 0.
//   Exposes its next-state value so the parent can register decoded outputs
//   that line up with the counter value on the same cycle.
//
// Ports
//   pixel_clock  in   1      counting clock
//   reset_n      in   1      asynchronous active-low reset (count -> LIMIT)
//   en           in   1      advance on this edge
//   count        out  WIDTH  registered count
//   count_next   out  WIDTH  value count will take on the next edge
//   wrap         out  1      en && count==LIMIT (next edge wraps to 0)
// ----------------------------------------------------------------------------
module wrap_counter #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    assign wrap = en && (count == LIMIT);

    always_comb begin
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + WIDTH'(1);
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= LIMIT;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing
//   Raster timing generator. Produces beam position, horizontal/vertical sync,
//   a visible-area flag and line/frame start pulses, all on pixel_clock.
//   Every output is a flop whose D input is decoded from the counters'
//   next-state values, so all outputs describe the same (pixel_x, pixel_y).
//
// Ports
//   pixel_clock      in   1       pixel clock
//   reset_n          in   1       asynchronous active-low reset
//   pixel_x          out  CRM+1   current column, 0..H_TOTAL-1
//   pixel_y          out  CRM+1   current line, 0..V_TOTAL-1
//   horizontal_sync  out  1       H_SYNC_POL level inside the hsync window
//   vertical_sync    out  1       V_SYNC_POL level inside the vsync lines
//   visible          out  1       x<H_VISIBLE and y<V_VISIBLE
//   line_start       out  1       pulse at pixel_x==0
//   frame_start      out  1       pulse at (0,0)
//   frame_count      out  16      only with VGA_FRAME_COUNT_EN: frames since
//                                 reset, first frame reads 1, wraps at 16'hFFFF
//
// Build option
//   VGA_FRAME_COUNT_EN  adds the frame_count port and counter.
// ----------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int COORD_REG_MAX = DEF_COORD_REG_MAX,
    parameter int H_VISIBLE     = DEF_H_VISIBLE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_VISIBLE     = DEF_V_VISIBLE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter bit H_SYNC_POL    = DEF_H_SYNC_POL,
    parameter bit V_SYNC_POL    = DEF_V_SYNC_POL
) (
    input  logic                     pixel_clock,
    input  logic                     reset_n,
    output logic [COORD_REG_MAX:0]   pixel_x,
    output logic [COORD_REG_MAX:0]   pixel_y,
    output logic                     horizontal_sync,
    output logic                     vertical_sync,
    output logic                     visible,
    output logic                     line_start,
    output logic                     frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,output logic [FRAME_COUNT_W-1:0] frame_count
`endif
);

    localparam int COORD_W = COORD_REG_MAX + 1;
    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (!coord_fits(H_TOTAL, COORD_W)) begin : g_h_range_err
        $error("vga_timing: H_TOTAL-1 does not fit in pixel_x");
    end
    if (!coord_fits(V_TOTAL, COORD_W)) begin : g_v_range_err
        $error("vga_timing: V_TOTAL-1 does not fit in pixel_y");
    end

    localparam logic [COORD_REG_MAX:0] X_LIMIT    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_REG_MAX:0] Y_LIMIT    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_REG_MAX:0] X_VISIBLE  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_REG_MAX:0] Y_VISIBLE  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_REG_MAX:0] HS_FIRST   = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_REG_MAX:0] HS_LAST    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_REG_MAX:0] VS_FIRST   = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_REG_MAX:0] VS_LAST    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [COORD_REG_MAX:0] x_next;
    logic [COORD_REG_MAX:0] y_next;
    logic                   x_wrap;
    logic                   y_wrap;

    logic hsync_active;
    logic vsync_active;
    logic visible_next;

    wrap_counter #(
        .WIDTH (COORD_W),
        .LIMIT (X_LIMIT)
    ) u_x_counter (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .en          (1'b1),
        .count       (pixel_x),
        .count_next  (x_next),
        .wrap        (x_wrap)
    );

    wrap_counter #(
        .WIDTH (COORD_W),
        .LIMIT (Y_LIMIT)
    ) u_y_counter (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .en          (x_wrap),
        .count       (pixel_y),
        .count_next  (y_next),
        .wrap        (y_wrap)
    );

    // Decode is done on the next-state position; y_next only moves on an
    // x wrap, so vsync can only change at the start of a line.
    always_comb begin
        hsync_active = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
        vsync_active = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
        visible_next = (x_next < X_VISIBLE) && (y_next < Y_VISIBLE);
    end

    // x_wrap means the next position has x==0; y_wrap (x wrap on the last
    // line) means the next position is (0,0).
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            horizontal_sync <= ~H_SYNC_POL;
            vertical_sync   <= ~V_SYNC_POL;
            visible         <= 1'b0;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            horizontal_sync <= hsync_active ? H_SYNC_POL : ~H_SYNC_POL;
            vertical_sync   <= vsync_active ? V_SYNC_POL : ~V_SYNC_POL;
            visible         <= visible_next;
            line_start      <= x_wrap;
            frame_start     <= y_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (y_wrap) begin
            frame_count <= frame_count + FRAME_COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

    localparam int HT    = 14;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;

    logic pixel_clock = 1'b0;
    logic reset_n     = 1'b0;

    logic [11:0] px, py, px_i, py_i;
    logic hs, vs, vis, ls, fs;
    logic hs_i, vs_i, vis_i, ls_i, fs_i;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc, fc_i;
`endif

    int checks   = 0;
    int failures = 0;
    int p        = FRAME - 1;   // model: linear raster position
    int fc_exp   = 0;

    always #5 pixel_clock = ~pixel_clock;

    vga_timing #(
        .COORD_REG_MAX(11), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .pixel_x(px), .pixel_y(py), .horizontal_sync(hs), .vertical_sync(vs),
        .visible(vis), .line_start(ls), .frame_start(fs)
`ifdef VGA_FRAME_COUNT_EN
       ,.frame_count(fc)
`endif
    );

    vga_timing #(
        .COORD_REG_MAX(11), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_inv (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .pixel_x(px_i), .pixel_y(py_i), .horizontal_sync(hs_i), .vertical_sync(vs_i),
        .visible(vis_i), .line_start(ls_i), .frame_start(fs_i)
`ifdef VGA_FRAME_COUNT_EN
       ,.frame_count(fc_i)
`endif
    );

    // Reference model: position q in 0..FRAME-1, x = q mod HT, y = q div HT.
    function automatic int mx(input int q); return q % HT; endfunction
    function automatic int my(input int q); return q / HT; endfunction
    function automatic logic m_hs(input int q, input logic pol);
        return (mx(q) >= 10 && mx(q) <= 11) ? pol : ~pol;
    endfunction
    function automatic logic m_vs(input int q, input logic pol);
        return (my(q) == 5) ? pol : ~pol;
    endfunction
    function automatic logic m_vis(input int q);
        return (mx(q) < 8) && (my(q) < 4);
    endfunction

    task automatic tick();
        @(posedge pixel_clock);
        p = (p + 1) % FRAME;
        if (p == 0) fc_exp = (fc_exp + 1) % 65536;
        @(negedge pixel_clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; p = FRAME - 1; fc_exp = 0;
        repeat (3) @(negedge pixel_clock);
        checks++; if (px !== 12'd13) begin failures++; $display("FAIL reset_x got=%0d exp=13", px); end
        checks++; if (py !== 12'd7)  begin failures++; $display("FAIL reset_y got=%0d exp=7", py); end
        checks++; if (hs !== 1'b1)   begin failures++; $display("FAIL reset_hsync got=%b exp=1", hs); end
        checks++; if (vs !== 1'b1)   begin failures++; $display("FAIL reset_vsync got=%b exp=1", vs); end
        checks++; if (vis !== 1'b0 || ls !== 1'b0 || fs !== 1'b0)
            begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", vis, ls, fs); end
        checks++; if (hs_i !== 1'b0 || vs_i !== 1'b0)
            begin failures++; $display("FAIL reset_inv_sync got=%b%b exp=00", hs_i, vs_i); end
`ifdef VGA_FRAME_COUNT_EN
        checks++; if (fc !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", fc); end
`endif
        reset_n = 1'b1;
        tick();
        checks++; if (px !== 12'd0 || py !== 12'd0)
            begin failures++; $display("FAIL first_pos got=(%0d,%0d) exp=(0,0)", px, py); end
        checks++; if (fs !== 1'b1 || ls !== 1'b1 || vis !== 1'b1)
            begin failures++; $display("FAIL first_flags fs/ls/vis got=%b%b%b exp=111", fs, ls, vis); end
    endtask

    task automatic test_line_timing();
        int last = -1;
        for (int c = 0; c < 3 * HT; c++) begin
            tick();
            checks++; if (px !== 12'(mx(p))) begin failures++; $display("FAIL line_x got=%0d exp=%0d", px, mx(p)); end
            checks++; if (hs !== m_hs(p, 1'b0)) begin failures++; $display("FAIL line_hsync x=%0d got=%b exp=%b", mx(p), hs, m_hs(p, 1'b0)); end
            checks++; if (vis !== m_vis(p)) begin failures++; $display("FAIL line_visible x=%0d got=%b exp=%b", mx(p), vis, m_vis(p)); end
            checks++; if (ls !== (mx(p) == 0)) begin failures++; $display("FAIL line_start x=%0d got=%b", mx(p), ls); end
            if (ls) begin
                if (last >= 0) begin
                    checks++; if (c - last != HT) begin failures++; $display("FAIL line_period got=%0d exp=%0d", c - last, HT); end
                end
                last = c;
            end
        end
    endtask

    task automatic test_frame_timing();
        int  last = -1;
        int  vs_low = 0;
        int  vis_cnt = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            checks++; if (py !== 12'(my(p))) begin failures++; $display("FAIL frame_y got=%0d exp=%0d", py, my(p)); end
            checks++; if (vs !== m_vs(p, 1'b0)) begin failures++; $display("FAIL frame_vsync y=%0d got=%b exp=%b", my(p), vs, m_vs(p, 1'b0)); end
            checks++; if (fs !== (p == 0)) begin failures++; $display("FAIL frame_start pos=%0d got=%b", p, fs); end
            if (fs) begin
                if (last >= 0) begin
                    checks++; if (c - last != FRAME) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", c - last, FRAME); end
                    checks++; if (vs_low != 14) begin failures++; $display("FAIL vsync_cycles got=%0d exp=14", vs_low); end
                    checks++; if (vis_cnt != 32) begin failures++; $display("FAIL visible_cycles got=%0d exp=32", vis_cnt); end
                end
                last = c; vs_low = 0; vis_cnt = 0;
            end
            if (last >= 0) begin
                if (vs == 1'b0) vs_low++;
                if (vis) vis_cnt++;
            end
        end
    endtask

    task automatic test_inverted_sync();
        int hs_hi = 0;
        int vs_hi = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            checks++; if (hs_i !== m_hs(p, 1'b1)) begin failures++; $display("FAIL inv_hsync x=%0d got=%b exp=%b", mx(p), hs_i, m_hs(p, 1'b1)); end
            checks++; if (vs_i !== m_vs(p, 1'b1)) begin failures++; $display("FAIL inv_vsync y=%0d got=%b exp=%b", my(p), vs_i, m_vs(p, 1'b1)); end
            checks++; if (px_i !== 12'(mx(p)) || py_i !== 12'(my(p)))
                begin failures++; $display("FAIL inv_pos got=(%0d,%0d) exp=(%0d,%0d)", px_i, py_i, mx(p), my(p)); end
            checks++; if (vis_i !== m_vis(p) || ls_i !== (mx(p) == 0) || fs_i !== (p == 0))
                begin failures++; $display("FAIL inv_flags pos=%0d got=%b%b%b", p, vis_i, ls_i, fs_i); end
            if (hs_i) hs_hi++;
            if (vs_i) vs_hi++;
        end
        checks++; if (hs_hi != 2 * VT) begin failures++; $display("FAIL inv_hsync_count got=%0d exp=%0d", hs_hi, 2 * VT); end
        checks++; if (vs_hi != HT) begin failures++; $display("FAIL inv_vsync_count got=%0d exp=%0d", vs_hi, HT); end
    endtask

    task automatic test_mid_reset();
        int target = 3 * HT + 6;
        for (int k = 0; k < FRAME && p != target; k++) tick();
        checks++; if (px !== 12'd6 || py !== 12'd3)
            begin failures++; $display("FAIL mid_reset_reach got=(%0d,%0d) exp=(6,3)", px, py); end
        #2;
        reset_n = 1'b0; p = FRAME - 1; fc_exp = 0;
        #1;
        checks++; if (px !== 12'd13 || py !== 12'd7)
            begin failures++; $display("FAIL mid_reset_pos got=(%0d,%0d) exp=(13,7)", px, py); end
        checks++; if (hs !== 1'b1 || vs !== 1'b1 || vis !== 1'b0 || ls !== 1'b0 || fs !== 1'b0)
            begin failures++; $display("FAIL mid_reset_flags got=%b%b%b%b%b exp=11000", hs, vs, vis, ls, fs); end
        @(negedge pixel_clock);
        reset_n = 1'b1;
        tick();
        checks++; if (px !== 12'd0 || py !== 12'd0 || fs !== 1'b1)
            begin failures++; $display("FAIL mid_reset_restart got=(%0d,%0d) fs=%b exp=(0,0) fs=1", px, py, fs); end
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 16; it++) begin
            int n = $urandom_range(5, 200);
            for (int c = 0; c < n; c++) begin
                tick();
                checks++; if (px !== 12'(mx(p)) || py !== 12'(my(p)))
                    begin failures++; $display("FAIL rnd_pos got=(%0d,%0d) exp=(%0d,%0d)", px, py, mx(p), my(p)); end
                checks++; if (hs !== m_hs(p, 1'b0) || vs !== m_vs(p, 1'b0))
                    begin failures++; $display("FAIL rnd_sync pos=%0d got=%b%b exp=%b%b", p, hs, vs, m_hs(p, 1'b0), m_vs(p, 1'b0)); end
                checks++; if (vis !== m_vis(p) || ls !== (mx(p) == 0) || fs !== (p == 0))
                    begin failures++; $display("FAIL rnd_flags pos=%0d got=%b%b%b", p, vis, ls, fs); end
`ifdef VGA_FRAME_COUNT_EN
                checks++; if (fc !== 16'(fc_exp)) begin failures++; $display("FAIL rnd_frame_count got=%0d exp=%0d", fc, fc_exp); end
`endif
            end
            #($urandom_range(1, 4));
            reset_n = 1'b0; p = FRAME - 1; fc_exp = 0;
            #1;
            checks++; if (px !== 12'd13 || py !== 12'd7 || fs !== 1'b0)
                begin failures++; $display("FAIL rnd_reset got=(%0d,%0d) fs=%b exp=(13,7) fs=0", px, py, fs); end
            repeat ($urandom_range(1, 3)) @(negedge pixel_clock);
            reset_n = 1'b1;
        end
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_count();
        int k = 0;
        reset_n = 1'b0; p = FRAME - 1; fc_exp = 0;
        @(negedge pixel_clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4 * FRAME && k < 3; c++) begin
            tick();
            if (fs) begin
                k++;
                checks++; if (fc !== 16'(k)) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", fc, k); end
            end
        end
        checks++; if (k != 3) begin failures++; $display("FAIL frame_count_frames got=%0d exp=3", k); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_inverted_sync();
        test_mid_reset();
        test_random_resets();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
